// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Front end of the Mips32 core. Receives a program as a byte
//             stream (valid/ready) and packs the bytes into 32-bit
//             little-endian words. The first word is the word count N, and
//             the N words that follow are written into an internal
//             instruction memory. The loader then holds the core in reset
//             for RELEASE_CYCLES more cycles, releases it, and serves
//             combinational instruction fetches. It also tracks the core's
//             halt flag and reports load and run status.
//  Optional : IMEM_CHECKSUM_EN - one extra word after the program must equal
//             the XOR of the header and all program words.
//  Ports    : clock, reset     - clock, synchronous active-high reset
//             in_valid/in_ready/in_data - byte stream handshake
//             raddr / instr    - word fetch address / instruction (comb.)
//             cpu_reset        - reset to the core (active-high)
//             halted           - halt flag from the core
//             loaded/done/error- status outputs
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int ADDR_SIZE      = 8,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic [31:0] raddr,
   output logic [31:0] instr,
   output logic        cpu_reset,
   input  logic        halted,
   output logic        loaded,
   output logic        done,
   output logic        error
);

   localparam int unsigned c_DEPTH    = 1 << ADDR_SIZE;
   localparam logic [31:0] c_DEPTH_W  = 32'(c_DEPTH);
   localparam logic [31:0] c_BREAK    = 32'h0000_000D;
   localparam logic [7:0]  c_REL_INIT = 8'(RELEASE_CYCLES);

   typedef enum logic [2:0] {
      S_HEADER  = 3'd0,
      S_LOAD    = 3'd1,
`ifdef IMEM_CHECKSUM_EN
      S_CSUM    = 3'd2,
`endif
      S_RELEASE = 3'd3,
      S_RUN     = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   state_t                 r_state;
   logic                   r_in_ready;
   logic                   r_cpu_reset;
   logic                   r_loaded;
   logic                   r_done;
   logic                   r_error;
   logic [1:0]             r_byte_cnt;
   logic [23:0]            r_word_buf;
   logic [ADDR_SIZE:0]     r_count;     // N; one extra bit so N=DEPTH fits
   logic [ADDR_SIZE-1:0]   r_wr_ptr;
   logic [7:0]             r_rel_cnt;
   logic [31:0]            r_mem [c_DEPTH];
`ifdef IMEM_CHECKSUM_EN
   logic [31:0]            r_csum;
`endif

   logic                   w_accept;
   logic                   w_word_done;
   logic [31:0]            w_word;
   logic                   w_hdr_ok;
   logic                   w_last;
   logic                   w_mem_we;
   logic [ADDR_SIZE:0]     w_n_eff;

   assign w_accept    = in_valid & r_in_ready;
   assign w_word_done = w_accept & (r_byte_cnt == 2'd3);
   // Byte 3 goes straight from the input into the top of the word so the
   // word is usable on the edge that accepts it.
   assign w_word      = {in_data, r_word_buf};
   assign w_hdr_ok    = (w_word != 32'd0) && (w_word <= c_DEPTH_W);
   assign w_last      = ({1'b0, r_wr_ptr} == (r_count - {{ADDR_SIZE{1'b0}}, 1'b1}));
   assign w_mem_we    = ~reset & w_word_done & (r_state == S_LOAD);

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_HEADER;
         r_in_ready  <= 1'b0;
         r_cpu_reset <= 1'b1;
         r_loaded    <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_byte_cnt  <= 2'd0;
         r_word_buf  <= 24'd0;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rel_cnt   <= 8'd0;
`ifdef IMEM_CHECKSUM_EN
         r_csum      <= 32'd0;
`endif
      end else begin
         // Byte packing runs whenever a byte is accepted, in any state.
         if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
               2'd0:    r_word_buf[7:0]   <= in_data;
               2'd1:    r_word_buf[15:8]  <= in_data;
               2'd2:    r_word_buf[23:16] <= in_data;
               default: r_word_buf        <= r_word_buf;
            endcase
         end

         case (r_state)
            S_HEADER: begin
               r_in_ready <= 1'b1;
               if (w_word_done) begin
                  if (w_hdr_ok) begin
                     r_count  <= w_word[ADDR_SIZE:0];
                     r_wr_ptr <= '0;
                     r_state  <= S_LOAD;
`ifdef IMEM_CHECKSUM_EN
                     r_csum   <= w_word;
`endif
                  end else begin
                     r_state    <= S_ERROR;
                     r_error    <= 1'b1;
                     r_in_ready <= 1'b0;
                  end
               end
            end

            S_LOAD: begin
               if (w_word_done) begin
                  // Wraps to 0 after the final write when N=DEPTH; unused then.
                  r_wr_ptr <= r_wr_ptr + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                  r_csum   <= r_csum ^ w_word;
                  if (w_last) begin
                     r_state <= S_CSUM;
                  end
`else
                  if (w_last) begin
                     r_state    <= S_RELEASE;
                     r_loaded   <= 1'b1;
                     r_in_ready <= 1'b0;
                     r_rel_cnt  <= c_REL_INIT;
                  end
`endif
               end
            end

`ifdef IMEM_CHECKSUM_EN
            S_CSUM: begin
               if (w_word_done) begin
                  r_in_ready <= 1'b0;
                  if (w_word == r_csum) begin
                     r_state   <= S_RELEASE;
                     r_loaded  <= 1'b1;
                     r_rel_cnt <= c_REL_INIT;
                  end else begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
`endif

            S_RELEASE: begin
               r_rel_cnt <= r_rel_cnt - 8'd1;
               if (r_rel_cnt == 8'd1) begin
                  r_state     <= S_RUN;
                  r_cpu_reset <= 1'b0;
               end
            end

            S_RUN: begin
               if (halted) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end

            S_DONE: begin
               r_done <= 1'b1;
            end

            S_ERROR: begin
               r_error     <= 1'b1;
               r_cpu_reset <= 1'b1;
               r_in_ready  <= 1'b0;
            end

            default: begin
               r_state     <= S_ERROR;
               r_error     <= 1'b1;
               r_cpu_reset <= 1'b1;
               r_in_ready  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Instruction memory: written only while loading, never cleared by reset
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // N is only visible to the fetch port once the load has completed, so a
   // core fetching early sees nothing but break instructions.
   assign w_n_eff = r_loaded ? r_count : '0;
   assign instr   = (raddr < 32'(w_n_eff)) ? r_mem[raddr[ADDR_SIZE-1:0]] : c_BREAK;

   assign in_ready  = r_in_ready;
   assign cpu_reset = r_cpu_reset;
   assign loaded    = r_loaded;
   assign done      = r_done;
   assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. A word-count based model
//             tracks what the loader must show each cycle; a compare process
//             checks every output against it after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int          ADDR_SIZE      = 8;
   localparam int          RELEASE_CYCLES = 4;
   localparam int unsigned DEPTH          = 1 << ADDR_SIZE;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'd0;
   logic [31:0] raddr = 32'd0;
   logic [31:0] instr;
   logic        cpu_reset;
   logic        halted = 1'b0;
   logic        loaded;
   logic        done;
   logic        error;

   imem_loader #(.ADDR_SIZE(ADDR_SIZE), .RELEASE_CYCLES(RELEASE_CYCLES)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .raddr(raddr), .instr(instr), .cpu_reset(cpu_reset),
      .halted(halted), .loaded(loaded), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [DEPTH];
   int          m_nb;       // bytes held toward current word
   logic [31:0] m_asm;
   int          m_nw;       // complete words seen since reset
   int unsigned m_n;
   bit          m_err, m_loaded, m_done, m_ready, m_valid;
   int          m_rel;      // cycles of reset still owed to the core
   logic [31:0] m_csum;

   task automatic m_finish_load();
      m_loaded = 1'b1;
      m_rel    = RELEASE_CYCLES;
   endtask

   task automatic m_take_word(input logic [31:0] w);
      int idx;
      idx = m_nw;
      m_nw++;
      if (idx == 0) begin
         if (w >= 32'd1 && w <= 32'(DEPTH)) begin
            m_n    = w;
            m_csum = w;
         end else begin
            m_err = 1'b1;
         end
      end else if (idx <= int'(m_n)) begin
         m_mem[(idx - 1) % DEPTH] = w;
         m_csum = m_csum ^ w;
`ifndef IMEM_CHECKSUM_EN
         if (idx == int'(m_n)) m_finish_load();
`endif
      end
`ifdef IMEM_CHECKSUM_EN
      else if (idx == int'(m_n) + 1) begin
         if (w == m_csum) m_finish_load();
         else             m_err = 1'b1;
      end
`endif
   endtask

   // Called once per rising edge with the inputs that were stable at it.
   task automatic model_step();
      bit acc, was_running;
      if (reset) begin
         m_nb = 0; m_asm = 32'd0; m_nw = 0; m_n = 0;
         m_err = 0; m_loaded = 0; m_done = 0; m_ready = 0; m_rel = 0;
         m_csum = 32'd0; m_valid = 1'b1;
      end else begin
         acc         = in_valid && m_ready;
         was_running = m_loaded && (m_rel == 0) && !m_err;
         if (was_running && halted) m_done = 1'b1;
         if (m_loaded && m_rel > 0) m_rel--;
         if (acc) begin
            m_asm[8*m_nb +: 8] = in_data;
            m_nb++;
            if (m_nb == 4) begin
               m_nb = 0;
               m_take_word(m_asm);
            end
         end
         m_ready = !m_err && !m_loaded;
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      logic [31:0] exp_instr;
      forever begin
         @(posedge clock);
         #1;
         if (m_valid) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("cpu_reset", 32'(cpu_reset), 32'(m_err || !(m_loaded && m_rel == 0)));
            chk("loaded", 32'(loaded), 32'(m_loaded));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            exp_instr = (m_loaded && raddr < m_n) ? m_mem[raddr % DEPTH] : 32'h0000_000D;
            chk("instr", instr, exp_instr);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0]  q[$];
   int          duty     = 100;
   bit          rst_drv  = 1'b1;
   bit          halt_drv = 1'b0;
   bit          use_hold = 1'b0;
   logic [31:0] raddr_hold = 32'd0;
   int unsigned cur_n = 1;

   task automatic cycle();
      bit will;
      int sel;
      @(negedge clock);
      reset    = rst_drv;
      halted   = halt_drv;
      in_valid = (q.size() > 0) && ($urandom_range(99) < duty);
      in_data  = (q.size() > 0) ? q[0] : 8'($urandom);
      if (use_hold) raddr = raddr_hold;
      else begin
         sel = $urandom_range(3);
         if (sel == 0)      raddr = $urandom;
         else if (sel == 1) raddr = cur_n + $urandom_range(4) - 2;
         else               raddr = $urandom_range(7);
      end
      will = in_valid && in_ready && !reset;
      @(posedge clock);
      model_step();
      if (will) void'(q.pop_front());
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
   endtask

   task automatic do_reset(input int n);
      q.delete();
      rst_drv = 1'b1;
      repeat (n) cycle();
      rst_drv = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d bytes left, required 0", q.size());
      end
   endtask

   task automatic fetch(input string nm, input logic [31:0] a, input logic [31:0] exp);
      use_hold = 1'b1; raddr_hold = a;
      cycle();
      chk(nm, instr, exp);
      use_hold = 1'b0;
   endtask

   logic [31:0] words [8];

   initial begin
      int k;
      // ---- reset state ----
      do_reset(3);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_loaded", 32'(loaded), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      cycle();
      chk("first_free_in_ready", 32'(in_ready), 32'd1);

      // ---- test 1: 3-word program ----
      cur_n = 3; duty = 100;
      push_word(32'd3);
      push_word(32'hDEAD_0001); push_word(32'h0BAD_F00D); push_word(32'h1234_5678);
      drain(200);
      chk("t1_loaded_last_edge", 32'(loaded), 32'd1);
      chk("t1_cpu_reset_held", 32'(cpu_reset), 32'd1);
      k = 0;
      while (cpu_reset && k < 20) begin cycle(); k++; end
      chk("t1_release_cycles", 32'(k), 32'd4);
      fetch("t1_w0", 32'd0, 32'hDEAD_0001);
      fetch("t1_w1", 32'd1, 32'h0BAD_F00D);
      fetch("t1_w2", 32'd2, 32'h1234_5678);
      fetch("t1_brk", 32'd3, 32'h0000_000D);
      fetch("t1_brk_hi", 32'h8000_0001, 32'h0000_000D);

      // ---- test 4: halt tracking (after release) ----
      repeat (3) cycle();
      halt_drv = 1'b1; cycle(); halt_drv = 1'b0;
      chk("t4_done_next_edge", 32'(done), 32'd1);
      repeat (5) cycle();
      chk("t4_done_sticky", 32'(done), 32'd1);
      chk("t4_cpu_reset_low", 32'(cpu_reset), 32'd0);

      // halt pulse during RELEASE must be ignored
      do_reset(2);
      push_word(32'd1); push_word(32'hAAAA_5555);
      drain(100);
      halt_drv = 1'b1; cycle(); halt_drv = 1'b0;
      k = 0;
      while (cpu_reset && k < 20) begin cycle(); k++; end
      repeat (2) cycle();
      chk("t4_release_halt_ignored", 32'(done), 32'd0);

      // ---- test 2: bad headers ----
      do_reset(2);
      push_word(32'h0000_0000);
      drain(100); repeat (2) cycle();
      chk("t2_zero_error", 32'(error), 32'd1);
      chk("t2_zero_in_ready", 32'(in_ready), 32'd0);
      chk("t2_zero_cpu_reset", 32'(cpu_reset), 32'd1);
      do_reset(2);
      push_word(32'h0000_0101);
      drain(100); repeat (2) cycle();
      chk("t2_big_error", 32'(error), 32'd1);
      chk("t2_big_in_ready", 32'(in_ready), 32'd0);
      chk("t2_big_loaded", 32'(loaded), 32'd0);
      fetch("t2_big_brk", 32'd0, 32'h0000_000D);

      // ---- test 3: 5 words at 30% duty ----
      do_reset(2);
      cur_n = 5; duty = 30;
      push_word(32'd5);
      for (int i = 0; i < 5; i++) begin words[i] = $urandom; push_word(words[i]); end
      drain(2000);
      duty = 100;
      repeat (RELEASE_CYCLES + 1) cycle();
      for (int i = 0; i < 5; i++) fetch("t3_word", 32'(i), words[i]);
      fetch("t3_brk", 32'd5, 32'h0000_000D);

      // ---- test 5: reset mid-word, then fresh 1-word program ----
      do_reset(2);
      duty = 100;
      push_word(32'd2); push_word(32'h1111_2222); push_word(32'h3333_4444);
      k = 0;
      while (q.size() > 6 && k < 100) begin cycle(); k++; end
      chk("t5_partial_bytes_left", 32'(q.size()), 32'd6);
      do_reset(1);
      cur_n = 1;
      push_word(32'd1); push_word(32'hCAFE_BABE);
      drain(100);
      chk("t5_loaded", 32'(loaded), 32'd1);
      fetch("t5_w0", 32'd0, 32'hCAFE_BABE);
      fetch("t5_n_is_1", 32'd1, 32'h0000_000D);

      // ---- full-depth program ----
      do_reset(2);
      cur_n = DEPTH;
      push_word(32'(DEPTH));
      for (int i = 0; i < int'(DEPTH); i++) push_word(32'hA500_0000 | 32'(i));
`ifdef IMEM_CHECKSUM_EN
      begin
         logic [31:0] cs;
         cs = 32'(DEPTH);
         for (int i = 0; i < int'(DEPTH); i++) cs = cs ^ (32'hA500_0000 | 32'(i));
         push_word(cs);
      end
`endif
      drain(3000);
      chk("depth_loaded", 32'(loaded), 32'd1);
      fetch("depth_last", 32'(DEPTH - 1), 32'hA500_0000 | 32'(DEPTH - 1));
      fetch("depth_first", 32'd0, 32'hA500_0000);
      fetch("depth_over", 32'(DEPTH), 32'h0000_000D);
      fetch("depth_hi", 32'h0001_0005, 32'h0000_000D);

`ifdef IMEM_CHECKSUM_EN
      // ---- test 6: checksum ----
      do_reset(2);
      cur_n = 2;
      push_word(32'd2); push_word(32'h1234_5678); push_word(32'h0000_000D);
      push_word(32'h1234_5677);
      drain(200);
      chk("t6_good_loaded", 32'(loaded), 32'd1);
      chk("t6_good_error", 32'(error), 32'd0);
      do_reset(2);
      push_word(32'd2); push_word(32'h1234_5678); push_word(32'h0000_000D);
      push_word(32'h0000_0000);
      drain(200);
      chk("t6_bad_error", 32'(error), 32'd1);
      chk("t6_bad_loaded", 32'(loaded), 32'd0);
`endif

      repeat (3) cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Upstream stage of the Mips32 core. It receives a program as a byte stream over a valid/ready handshake and assembles the bytes into 32-bit little-endian words. It writes those words into an internal instruction memory, then releases the core from reset and serves its combinational instruction fetch. It also tracks the core's halt and reports load and run status.

Parameters:
ADDR_SIZE, 8, instruction memory address width in words; DEPTH = 2**ADDR_SIZE.
RELEASE_CYCLES, 4, cycles cpu_reset stays high after the last word is written (range 1..255).

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_data carries a byte.
in_ready  output  1  loader accepts a byte this cycle.
in_data  input  8  program byte stream.
raddr  input  32  word fetch address from the core (pc >> 2).
instr  output  32  fetched instruction, combinational.
cpu_reset  output  1  reset to the core, active-high.
halted  input  1  halt flag from the core.
loaded  output  1  program fully written.
done  output  1  core halted after a successful run.
error  output  1  bad header, or checksum mismatch when enabled.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports named clock and reset).
- Handshake: a byte transfers on a cycle with in_valid && in_ready. in_ready is a registered function of state: 1 in HEADER, LOAD and CSUM, 0 otherwise. No combinational path from in_valid to in_ready.
- Word assembly: 2-bit byte counter; byte k goes to bits [8k+7:8k]. The word completes on the edge that accepts byte 3; the counter wraps to 0.
- States: HEADER -> LOAD -> (CSUM) -> RELEASE -> RUN -> DONE; ERROR is absorbing.
- HEADER: the first word is count N.
  - 1 <= N <= DEPTH: latch N, wr_ptr=0, go to LOAD.
  - Otherwise: go to ERROR.
- LOAD: each completed word is written to mem[wr_ptr] on the same edge, then wr_ptr increments.
  - When wr_ptr reaches N-1 and is written, go to RELEASE (or CSUM when enabled).
  - Set loaded=1 on that edge.
- RELEASE: countdown from RELEASE_CYCLES; cpu_reset=1 throughout; go to RUN on the edge the counter reaches 0.
- RUN: cpu_reset=0. On the first cycle halted=1, go to DONE and set done=1.
- DONE: sticky until reset. cpu_reset stays 0; the core handles its own $finish.
- ERROR: error=1, cpu_reset=1, in_ready=0, sticky until reset.
- Fetch: instr = mem[raddr[ADDR_SIZE-1:0]] when raddr < N, else 32'h0000000D (break).
  - Compare the full 32 bits of raddr against N, so high-bit addresses also return break.
  - Before load completes N reads as 0, so every fetch returns break.
- Reset values:
  - in_ready=0 (first reset-free cycle: 1).
  - cpu_reset=1, loaded=0, done=0, error=0.
  - N=0, wr_ptr=0, byte counter=0, state HEADER.
  - Memory contents are not cleared.
- Reset mid-load or mid-run: abandon the partial word; all state returns to reset values; cpu_reset is reasserted on the next edge.
- A halted input outside RUN is ignored. Bytes presented while in_ready=0 are not consumed.
- N=DEPTH: wr_ptr wraps to 0 after the final write; the wrapped value is never used.

Optional Feature:
- IMEM_CHECKSUM_EN defined:
  - After the N program words, one extra word in state CSUM is compared with the XOR of the header word and all N program words, accumulated as they are written.
  - Match: go to RELEASE and set loaded=1 on the CSUM completion edge.
  - Mismatch: go to ERROR; loaded stays 0.
- Not defined: no CSUM state and no accumulator; LOAD goes directly to RELEASE.

Test Plan:
1. Reset 3 cycles, then stream bytes 03 00 00 00, then three words -> loaded=1 on the last byte's edge; cpu_reset falls exactly RELEASE_CYCLES=4 cycles later; instr for raddr 0..2 equals the words; raddr=3 gives 0000000D.
2. Header 00000000, and separately header 00000101 with ADDR_SIZE=8 -> error=1, in_ready=0, cpu_reset stays 1.
3. Random in_valid gaps at 30% duty with a 5-word program -> word order and content unchanged; no byte lost or duplicated.
4. After release, raise halted for 1 cycle -> done=1 next edge and sticky; a halted pulse during RELEASE leaves done=0.
5. Assert reset after 2 bytes of word 1, then load a fresh 1-word program -> word 0 equals the new word and N=1.
6. With IMEM_CHECKSUM_EN, program N=2, words 12345678 and 0000000D -> CSUM 12345677 gives loaded=1; CSUM 00000000 gives error=1, loaded=0.
